// File: rtl/pipe_hazard_unit_pkg.sv
// Shared encodings and tracker entry layout for the pipeline hazard/forwarding unit.
package pipe_hazard_unit_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    // Forwarding select encodings: 0 = register file, k+1 = tracked stage k.
    localparam int FWD_RF  = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

    // Tracker entry layout: {addr, is_load, wr_en, valid}; control bits sit low
    // so the offsets stay fixed whatever the register address width.
    localparam int ENT_VALID    = 0;
    localparam int ENT_WR_EN    = 1;
    localparam int ENT_LOAD     = 2;
    localparam int ENT_ADDR_LSB = 3;
    localparam int ENT_CTRL_W   = 3;

    function automatic int ent_width(input int addr_w);
        return addr_w + ENT_CTRL_W;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_match.sv
// Priority encoder picking the youngest in-flight writer of one ID source operand.
module fwd_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int FWD_DEPTH  = 3,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1),
    parameter int ENT_W      = ent_width(REG_ADDR_W)
) (
    input  logic [REG_ADDR_W-1:0]      addr,
    input  logic                       uses,
    input  logic [FWD_DEPTH*ENT_W-1:0] tracker,
    output logic [SEL_W-1:0]           sel,
    output logic                       load_hazard
);

    logic             found;
    logic [ENT_W-1:0] ent;

    always_comb begin
        sel         = '0;
        load_hazard = 1'b0;
        found       = 1'b0;
        ent         = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            ent = tracker[k*ENT_W +: ENT_W];
            // r0 is hardwired zero, so writers of r0 never forward.
            if (!found && uses && (addr != '0) && ent[ENT_VALID] && ent[ENT_WR_EN]
                && (ent[ENT_ADDR_LSB +: REG_ADDR_W] == addr)) begin
                found       = 1'b1;
                sel         = SEL_W'(k + 1);
                load_hazard = ent[ENT_LOAD] && (k < LOAD_READY);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline: tracks in-flight
// destinations, drives forwarding selects, load-use stall and redirect flush.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
    parameter int FWD_DEPTH      = 3,
    parameter int LOAD_READY     = 2,
    parameter int REDIRECT_STAGE = 2,
    parameter int CNT_W          = 16,
    parameter int SEL_W          = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_wr_addr,
    input  logic                  id_is_load,
    input  logic                  redirect,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic                  stall,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int ENT_W = ent_width(REG_ADDR_W);

    logic [ENT_W-1:0]           ent [FWD_DEPTH];
    logic [FWD_DEPTH*ENT_W-1:0] tracker;
    logic [ENT_W-1:0]           new_ent;
    logic                       haz_a;
    logic                       haz_b;
    logic                       insert;

    for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_flat
        assign tracker[g*ENT_W +: ENT_W] = ent[g];
    end

    fwd_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_DEPTH  (FWD_DEPTH),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W),
        .ENT_W      (ENT_W)
    ) u_match_a (
        .addr        (id_rs),
        .uses        (id_uses_rs),
        .tracker     (tracker),
        .sel         (fwd_a_sel),
        .load_hazard (haz_a)
    );

    fwd_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_DEPTH  (FWD_DEPTH),
        .LOAD_READY (LOAD_READY),
        .SEL_W      (SEL_W),
        .ENT_W      (ENT_W)
    ) u_match_b (
        .addr        (id_rt),
        .uses        (id_uses_rt),
        .tracker     (tracker),
        .sel         (fwd_b_sel),
        .load_hazard (haz_b)
    );

    // A redirect squashes the ID instruction anyway, so it overrides the stall.
    assign stall       = id_valid & ~redirect & (haz_a | haz_b);
    assign pc_we       = ~stall;
    assign ifid_we     = ~stall;
    assign ifid_flush  = redirect;
    assign idex_bubble = stall | redirect;
    assign insert      = id_valid & ~stall & ~redirect;
    assign new_ent     = {id_wr_addr, id_is_load, id_wr_en, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                ent[k] <= '0;
            end
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            // Wrong-path entries younger than the resolving branch shift in as invalid.
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                if (redirect && ((k - 1) < REDIRECT_STAGE)) begin
                    ent[k] <= '0;
                end else begin
                    ent[k] <= ent[k-1];
                end
            end
            ent[0] <= insert ? new_ent : '0;
            if (stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
